// File: rtl/imem_pkg.sv
// Constants and FSM encoding shared by the instruction memory and its loader.
package imem_pkg;

   localparam int IMEM_DEPTH  = 1024;
   localparam int IMEM_ADDR_W = 10;
   localparam int WORD_SHIFT  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } ld_state_t;

   function automatic logic [31:0] word2byte(input logic [31:0] widx);
      return widx << WORD_SHIFT;
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs little-endian bytes into a 32-bit word; word_out is valid in the cycle of the 4th accept.
// No backpressure of its own: the caller decides when a byte is accepted.
module imem_word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_out,
   output logic        word_full
);

   logic [23:0] shreg;
   logic [1:0]  byte_idx;

   // Earlier bytes shift down, so the current byte always lands in the top lane.
   assign word_out  = {byte_in, shreg};
   assign word_full = accept && (byte_idx == 2'd3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg    <= '0;
         byte_idx <= '0;
      end else if (clear) begin
         byte_idx <= '0;
      end else if (accept) begin
         shreg    <= word_out[31:8];
         byte_idx <= byte_idx + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a host byte stream into instruction memory as consecutive words, holding the core meanwhile.
// mem_we one cycle after the 4th byte, done one cycle later; byte_ready low outside LOAD (5 cycles/word best case).
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH         = IMEM_DEPTH,
   parameter int ADDR_W        = IMEM_ADDR_W,
   parameter bit HOLD_AT_RESET = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [ADDR_W:0] len,
   input  logic            abort,
   input  logic            byte_valid,
   input  logic [7:0]      byte_data,
   output logic            byte_ready,
   output logic            mem_we,
   output logic [31:0]     mem_addr,
   output logic [31:0]     mem_wdata,
   output logic            cpu_hold,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [31:0]     checksum
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

   ld_state_t         state, state_d;
   logic [ADDR_W-1:0] word_cnt, word_cnt_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [31:0]       checksum_d, addr_d, wdata_d, word;
   logic              we_d, done_d, err_d, hold_d;
   logic              len_ok, last_word, accept, clear, word_full;

   assign len_ok    = (len != '0) && (len <= DEPTH_L);
   assign last_word = ({1'b0, word_cnt} == (len_q - ONE_L));
   // An abort in the same cycle drops the byte on offer.
   assign accept    = byte_valid && byte_ready && !abort;
   assign clear     = ((state == IDLE) && start && len_ok) ||
                      (abort && ((state == LOAD) || (state == WRITE)));

   imem_word_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .accept    (accept),
      .byte_in   (byte_data),
      .word_out  (word),
      .word_full (word_full)
   );

   always_comb begin
      state_d    = state;
      word_cnt_d = word_cnt;
      len_d      = len_q;
      checksum_d = checksum;
      addr_d     = mem_addr;
      wdata_d    = mem_wdata;
      we_d       = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      hold_d     = cpu_hold;
      case (state)
         IDLE: begin
            if (start) begin
               if (len_ok) begin
                  state_d    = LOAD;
                  word_cnt_d = '0;
                  len_d      = len;
                  checksum_d = '0;
                  hold_d     = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (abort) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (word_full) begin
               state_d = WRITE;
               we_d    = 1'b1;
               addr_d  = word2byte(32'(word_cnt));
               wdata_d = word;
            end
         end
         WRITE: begin
            // The write in flight always lands, so it always counts toward the sum.
            checksum_d = checksum + mem_wdata;
            if (abort) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (last_word) begin
               state_d = DONE;
               done_d  = 1'b1;
               hold_d  = 1'b0;
            end else begin
               state_d    = LOAD;
               word_cnt_d = word_cnt + ADDR_W'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         word_cnt   <= '0;
         len_q      <= '0;
         checksum   <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         cpu_hold   <= HOLD_AT_RESET;
         byte_ready <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_d;
         word_cnt   <= word_cnt_d;
         len_q      <= len_d;
         checksum   <= checksum_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
         mem_we     <= we_d;
         done       <= done_d;
         err        <= err_d;
         cpu_hold   <= hold_d;
         byte_ready <= (state_d == LOAD);
         busy       <= (state_d == LOAD) || (state_d == WRITE);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised byte streams against a transaction-level model of the image loader.
module tb_imem_loader;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start, abort, byte_valid;
   logic [AW:0]   len;
   logic [7:0]    byte_data;
   logic          byte_ready, mem_we, cpu_hold, busy, done, err;
   logic [31:0]   mem_addr, mem_wdata, checksum;

   imem_loader #(.DEPTH(1024), .ADDR_W(AW), .HOLD_AT_RESET(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .abort      (abort),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  src[$];
   logic [31:0] wa[$], wd[$];
   int          wc[$], acc[$];
   logic        wh[$];
   int          n_done, n_err, done_cyc, err_cyc;
   logic        done_hold, exp_hold;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic mon();
      if (mem_we) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_wdata);
         wc.push_back(cyc);
         wh.push_back(cpu_hold);
      end
      if (done) begin
         n_done++;
         done_cyc  = cyc;
         done_hold = cpu_hold;
      end
      if (err) begin
         n_err++;
         err_cyc = cyc;
      end
   endtask

   task automatic fill(input int n);
      src.delete();
      for (int i = 0; i < 4*n; i++) src.push_back(8'($urandom));
   endtask

   // mode: 0 valid always high, 1 valid toggles, 2 random valid.
   task automatic run_load(input int n, input int mode, input int abort_at, input bit poke);
      int          nb, idx, ew, budget, abort_edge;
      bit          aborted, tog, vld;
      logic [31:0] w, sum;
      nb = 4*n; idx = 0; aborted = 0; tog = 0; abort_edge = -1;
      wa.delete(); wd.delete(); wc.delete(); wh.delete(); acc.delete();
      n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1;
      @(negedge clk); start = 1'b1; len = (AW+1)'(n); byte_valid = 1'b0; abort = 1'b0;
      @(negedge clk); start = 1'b0; len = '0;
      exp_hold = 1'b1;
      budget = 12*nb + 40;
      for (int k = 0; k < budget; k++) begin
         mon();
         if (n_done != 0 || n_err != 0) break;
         start = 1'b0; abort = 1'b0;
         tog = ~tog;
         if (!aborted && abort_at >= 0 && idx == abort_at && byte_ready) begin
            abort      = 1'b1;
            aborted    = 1'b1;
            abort_edge = cyc + 1;
            byte_valid = 1'b1;
            byte_data  = src[idx];
         end else begin
            case (mode)
               0:       vld = 1'b1;
               1:       vld = tog;
               default: vld = 1'($urandom_range(0, 1));
            endcase
            byte_valid = vld && (idx < nb) && !aborted;
            byte_data  = byte_valid ? src[idx] : 8'($urandom);
            if (byte_valid && byte_ready) begin
               idx++;
               if (idx % 4 == 0) acc.push_back(cyc + 1);
            end
            if (poke && byte_ready && $urandom_range(0, 5) == 0) begin
               start = 1'b1;
               len   = '0;
            end
         end
         @(negedge clk);
      end
      byte_valid = 1'b0; abort = 1'b0; start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         mon();
      end
      check("end_evt", 32'((n_done + n_err) != 0), 1);
      ew  = aborted ? abort_at / 4 : n;
      sum = 0;
      for (int i = 0; i < ew; i++) begin
         w = {src[4*i+3], src[4*i+2], src[4*i+1], src[4*i]};
         sum += w;
         if (i < wa.size()) begin
            check("wr_addr", wa[i], 32'(i * 4));
            check("wr_data", wd[i], w);
            if (i < acc.size()) check("wr_lat", wc[i], acc[i]);
         end
      end
      check("wr_cnt", wa.size(), ew);
      check("cksum", checksum, sum);
      check("n_done", n_done, aborted ? 0 : 1);
      check("n_err", n_err, aborted ? 1 : 0);
      if (!aborted) exp_hold = 1'b0;
      check("hold", cpu_hold, exp_hold);
      check("busy_end", busy, 0);
      check("rdy_end", byte_ready, 0);
      if (aborted) begin
         check("err_lat", err_cyc, abort_edge);
      end else if (n_done != 0 && wc.size() != 0) begin
         check("done_lat", done_cyc, wc[wc.size()-1] + 1);
         check("hold_we", wh[wh.size()-1], 1);
         check("hold_done", done_hold, 0);
      end
   endtask

   task automatic bad_start(input logic [AW:0] l);
      @(negedge clk); start = 1'b1; len = l;
      @(negedge clk); start = 1'b0; len = '0;
      check("bad_err", err, 1);
      check("bad_busy", busy, 0);
      check("bad_rdy", byte_ready, 0);
      check("bad_hold", cpu_hold, exp_hold);
      @(negedge clk);
      check("bad_err_pulse", err, 0);
      check("bad_busy2", busy, 0);
   endtask

   initial begin
      int  n, mode, ab, idx;
      bit  seen;
      start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = '0; len = '0;
      exp_hold = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_hold", cpu_hold, 1);
      check("rst_we", mem_we, 0);
      check("rst_rdy", byte_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_cksum", checksum, 0);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_hold", cpu_hold, 1);
      check("post_rst_rdy", byte_ready, 0);

      bad_start(11'd0);

      src = {8'h13, 8'hFA, 8'h41, 8'h01, 8'h33, 8'h83, 8'h20, 8'h00};
      run_load(2, 0, -1, 0);
      check("dir_cksum", checksum, 32'h0162_7D46);
      if (wd.size() == 2) begin
         check("dir_w0", wd[0], 32'h0141_FA13);
         check("dir_w1", wd[1], 32'h0020_8333);
      end

      src = {8'h93, 8'h03, 8'h00, 8'h00};
      run_load(1, 1, -1, 0);
      if (wd.size() == 1) check("stall_w", wd[0], 32'h0000_0393);

      bad_start(11'd1025);

      fill(4); run_load(4, 0, 6, 0);
      fill(4); run_load(4, 0, -1, 0);
      fill(2); run_load(2, 0, 3, 0);

      for (int t = 0; t < 12; t++) begin
         n    = $urandom_range(1, 6);
         mode = $urandom_range(0, 2);
         ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4*n - 1)) : -1;
         fill(n);
         run_load(n, mode, ab, 1);
      end

      fill(1024); run_load(1024, 0, -1, 0);

      // Asynchronous reset while a word is being written.
      fill(1);
      @(negedge clk); start = 1'b1; len = 11'd1;
      @(negedge clk); start = 1'b0; len = '0;
      idx = 0; seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (mem_we) begin
            seen = 1;
         end else begin
            byte_valid = (idx < 4);
            byte_data  = src[(idx < 4) ? idx : 3];
            if (byte_valid && byte_ready) idx++;
            @(negedge clk);
         end
      end
      check("rw_seen", seen, 1);
      rst = 1'b0;
      #1;
      check("rw_we", mem_we, 0);
      check("rw_busy", busy, 0);
      check("rw_hold", cpu_hold, 1);
      check("rw_rdy", byte_ready, 0);
      byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_hold = 1'b1;
      @(negedge clk);
      check("rw_post_hold", cpu_hold, 1);
      check("rw_post_busy", busy, 0);
      fill(2); run_load(2, 2, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory's read port. Accepts a byte stream from a host/debug link, assembles little-endian 32-bit words and writes them to consecutive word-aligned instruction memory addresses.
- Holds the processor core in reset while an image is being loaded. Reports completion, a running checksum and errors.
- Sits between the host byte source and the instruction memory write port. cpu_hold feeds the core's reset logic.

Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words.
- ADDR_W, 10, word-index width, equal to clog2(DEPTH).
- HOLD_AT_RESET, 1, reset value of cpu_hold. 1 means the core is held until the first successful load.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  single-cycle load request; sampled only in IDLE.
- len  in  ADDR_W+1  number of words to load; legal range 1..DEPTH.
- abort  in  1  cancels a load in progress.
- byte_valid  in  1  host byte available.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  out  32  byte address, always word-aligned: word_index<<2, bits[1:0]=0.
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  1 = core held in reset.
- busy  out  1  high in LOAD and WRITE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on rejected start or abort.
- checksum  out  32  modulo-2^32 sum of all words written in the current/last load.

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - busy=0, done=0, err=0, checksum=0
  - cpu_hold=HOLD_AT_RESET
  - internal word_cnt=0, byte_idx=0
- Reset mid-load abandons everything immediately. Memory contents already written are not touched.

FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - start=1 with 1<=len<=DEPTH: go to LOAD; clear word_cnt, byte_idx and checksum; cpu_hold=1; latch len.
  - start=1 with len=0 or len>DEPTH: err pulses next cycle; stay in IDLE; cpu_hold unchanged.
- LOAD:
  - byte_ready=1.
  - A byte transfers when byte_valid&&byte_ready. The byte goes into lane byte_idx (first byte -> [7:0], fourth -> [31:24]), then byte_idx increments.
  - When the byte with byte_idx==3 is accepted, go to WRITE and set byte_idx=0.
  - byte_valid may stay high indefinitely; no bytes are lost or duplicated across the LOAD/WRITE boundary.
- WRITE:
  - byte_ready=0.
  - mem_we=1 for exactly one cycle, with mem_addr=word_cnt<<2 and mem_wdata=the assembled word.
  - checksum+=word, wrapping at 2^32.
  - If word_cnt==len-1, go to DONE; else increment word_cnt and go to LOAD.
- DONE: done=1 and cpu_hold=0 for one cycle, then go to IDLE. cpu_hold stays 0 in IDLE until the next accepted start.
- Latency:
  - Fourth byte accepted at edge N.
  - mem_we is high in cycle N+1.
  - For the last word, done=1 and cpu_hold=0 in cycle N+2.
  - Best case throughput is 5 cycles per word.
- abort:
  - Effective in LOAD or WRITE. Go to IDLE next cycle and pulse err.
  - The partial word is discarded; a word already in WRITE still completes its mem_we in that cycle.
  - cpu_hold stays 1, because the image is incomplete.
  - abort in the same cycle as a byte acceptance: abort wins and the byte is dropped.
  - abort in IDLE or DONE is ignored.
- start while busy is ignored, with no err.
- Word index never exceeds DEPTH-1, so mem_addr stays within 0..(DEPTH-1)*4 with no wrap.

Decomposition:
- Shared package imem_pkg holds:
  - the FSM state enum (IDLE/LOAD/WRITE/DONE)
  - IMEM_DEPTH=1024 and IMEM_ADDR_W=10
  - the word/byte-address conversion constant (shift 2)
- The instruction memory and this loader both use these constants.
- One natural sub-module: imem_word_packer. It holds byte_idx plus the 32-bit shift/lane register, and exposes byte_in/accept/word_out/word_full.
- The FSM, counters and checksum stay in imem_loader.

Test Plan:
- Reset with HOLD_AT_RESET=1: rst=0 then released -> cpu_hold=1, all other outputs 0, byte_ready=0.
- start, len=2, back-to-back bytes 13,FA,41,01,33,83,20,00:
  - mem_we at addr 0x0 data 0x0141FA13, then at addr 0x4 data 0x00208333.
  - checksum=0x0162_7D46.
  - done one cycle after the second mem_we; cpu_hold falls in the same cycle.
- Byte stall: byte_valid toggled 1/0 each cycle with len=1, data 93,03,00,00 -> a single mem_we with 0x00000393; no duplicate bytes.
- Error cases:
  - start with len=0 -> err=1 one cycle later, state stays IDLE, cpu_hold unchanged.
  - start with len=1025 -> same response.
- Abort after 2 bytes of word 1 (len=4) -> err pulse, only the word at 0x0 written, cpu_hold=1; a new start then loads correctly from address 0.
- Reset asserted while in WRITE -> mem_we drops immediately (asynchronous); after release the state is IDLE and cpu_hold=HOLD_AT_RESET.
